// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared data/address widths and data-memory responder FSM states
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with synchronous write and registered read
module dmem_array
  import pipe_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately never reset so they survive a pipeline reset.
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // One shared address: writes and reads never happen in the same cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder; DMEM_ALIGN_CHECK_EN enables misalignment errors
module dmem_responder
  import pipe_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Counter is loaded with WAIT_STATES-1 so the last WAIT cycle sees zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic [3:0]        wait_cnt;

  logic              cap_write;
  logic              cap_err;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_wdata;

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Upper address bits are dropped, so accesses wrap modulo the depth.
  assign req_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00);
`else
  assign req_err = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  // Next state and handshake outputs; reset masks every output in its own cycle.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      req_ready = 1'b0;
      stall     = 1'b0;
      rsp_valid = 1'b0;
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait-state down-counter, armed on accept and drained while in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Request capture; inputs are ignored after accept until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_err   <= req_err;
      cap_idx   <= req_idx;
      cap_wdata <= req_wdata;
    end
  end

  // The read is launched at the accept edge so data is ready even with zero
  // wait states; the store commits at the RESP exit edge using the captured
  // index, so a load accepted right after it already sees the new word.
  // rsp_valid is already masked by rst, which drops a store caught by reset.
  assign mem_re   = accept;
  assign mem_we   = rsp_valid && cap_write && !cap_err;
  assign mem_addr = (state == RESP) ? cap_idx : req_idx;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  assign rsp_rdata = (rsp_valid && !cap_write && !cap_err) ? mem_rdata : '0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign rsp_err = rsp_valid && cap_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (wait 2 and wait 0 instances)
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready,   z_req_ready;
  logic        rsp_valid,   z_rsp_valid;
  logic [31:0] rsp_rdata,   z_rsp_rdata;
  logic        rsp_err,     z_rsp_err;
  logic        stall,       z_stall;

  logic [31:0] ref_mem [DEPTH];
  int          n_checks;
  int          n_errs;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_z (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (z_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (z_rsp_valid),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err),
    .stall     (z_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete transaction, started at a negedge with both instances idle.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  idx;
    logic        err;
    logic [31:0] exp_rd;
    idx = a[9:2];
`ifdef DMEM_ALIGN_CHECK_EN
    err = (a[1:0] != 2'b00);
`else
    err = 1'b0;
`endif
    exp_rd = (!wr && !err) ? ref_mem[idx] : 32'h0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    #1;
    check("ready_idle", req_ready, 1);
    check("stall_idle", stall, 1);
    check("z_stall_idle", z_stall, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      check("rsp_valid_lat", rsp_valid, (k == W + 1));
      check("stall_busy", stall, (k <= W));
      check("ready_busy", req_ready, (k > W + 1));
      check("z_rsp_valid_lat", z_rsp_valid, (k == 1));
      check("z_stall_resp", z_stall, 0);
      if (k == W + 1) begin
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, err);
      end
      if (k == 1) begin
        check("z_rsp_rdata", z_rsp_rdata, exp_rd);
        check("z_rsp_err", z_rsp_err, err);
      end
    end
    if (wr && !err) ref_mem[idx] = d;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_w;
    n_checks  = 0;
    n_errs    = 0;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    // Reset state, with a request pending to show reset masks it.
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    check("z_ready_after_rst", z_req_ready, 1);
    @(negedge clk);

    // Fill every word so later loads have a known model value.
    for (int i = 0; i < DEPTH; i++) begin
      a = {$urandom_range(0, 1023), 2'b00};
      a[9:2] = 8'(i);
      xact(1'b1, a, $urandom);
    end

    // Directed patterns: basic store/load, zero-address, wraparound, misaligned.
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    xact(1'b0, 32'h0000_0010, 32'h0);
    check("deadbeef_model", ref_mem[4], 32'hDEAD_BEEF);
    xact(1'b1, 32'h0000_0000, 32'h0000_1234);
    xact(1'b0, 32'h0000_0000, 32'h0);
    xact(1'b1, 32'h0000_0400, 32'hA5A5_A5A5);
    xact(1'b0, 32'h0000_0000, 32'h0);
    xact(1'b1, 32'h0000_0020, 32'h1111_1111);
    xact(1'b1, 32'h0000_0022, 32'h2222_2222);
    xact(1'b0, 32'h0000_0020, 32'h0);

    // Reset during WAIT of a store: no response, store dropped.
    exp_w     = ref_mem[8];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_wait_stall", stall, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_rsp", rsp_valid, 0);
    check("rst_abort_stall", stall, 0);
    check("rst_abort_rdata", rsp_rdata, 0);
    check("z_rst_abort_rsp", z_rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("rst_abort_ready", req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    xact(1'b0, 32'h0000_0020, 32'h0);
    check("rst_word_kept", ref_mem[8], exp_w);

    // Random mix of loads and stores, some misaligned.
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xact(1'($urandom), a, $urandom);
    end

    // Continuous request: accept every W+2 cycles, stall 1,1,1,0 pattern.
    exp_w     = ref_mem[16];
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0040;
    req_wdata = 32'h0;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      #1;
      check("cont_stall", stall, ((i % (W + 2)) != W + 1));
      check("cont_rsp", rsp_valid, ((i % (W + 2)) == W + 1));
      if ((i % (W + 2)) == W + 1) check("cont_rdata", rsp_rdata, exp_w);
      check("cont_z_rsp", z_rsp_valid, ((i % 2) == 1));
      check("cont_z_stall", z_stall, ((i % 2) == 0));
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("drain_rsp", rsp_valid, 0);
    check("drain_ready", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
